// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle datapath control unit.
//   bus_t        : datapath word (the ALU zero flag arrives on a full bus)
//   ula_oper_t   : operation select consumed by the arithmetic unit
//   ctrl_state_t : the 13 sequencing states of multicycle_control
//   opcode_t / funct_t constants : instruction fields recognised by decode
//   alu_src_b_t / pc_src_t       : datapath mux selects
package types;

    typedef logic [31:0] bus_t;

    typedef enum logic [2:0] {
        ULA_ADD,
        ULA_SUB,
        ULA_AND,
        ULA_OR,
        ULA_NOR,
        ULA_SLT,
        ULA_SLTU
    } ula_oper_t;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_BRANCH,
        S_JUMP,
        S_IMM_EXEC,
        S_IMM_WB,
        S_ILLEGAL
    } ctrl_state_t;

    typedef logic [5:0] opcode_t;
    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_J     = 6'h02;
    localparam opcode_t OP_ADDI  = 6'h08;
    localparam opcode_t OP_SLTI  = 6'h0A;

    typedef logic [5:0] funct_t;
    localparam funct_t FN_ADD  = 6'h20;
    localparam funct_t FN_SUB  = 6'h22;
    localparam funct_t FN_AND  = 6'h24;
    localparam funct_t FN_OR   = 6'h25;
    localparam funct_t FN_NOR  = 6'h27;
    localparam funct_t FN_SLT  = 6'h2A;
    localparam funct_t FN_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

endpackage

// File: rtl/multicycle_control_funct_decode.sv
// funct_decode: combinational R-type funct decoder.
//   funct_i   : instr[5:0]
//   ula_sel_o : ALU operation for the funct (ADD when unrecognised)
//   legal_o   : 1 when funct names a supported R-type operation
module funct_decode
    import types::*;
(
    input  funct_t    funct_i,
    output ula_oper_t ula_sel_o,
    output logic      legal_o
);

    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        ula_sel_o = ULA_ADD;
        legal_o   = 1'b1;
        case (funct_i)
            FN_ADD:  ula_sel_o = ULA_ADD;
            FN_SUB:  ula_sel_o = ULA_SUB;
            FN_AND:  ula_sel_o = ULA_AND;
            FN_OR:   ula_sel_o = ULA_OR;
            FN_NOR:  ula_sel_o = ULA_NOR;
            FN_SLT:  ula_sel_o = ULA_SLT;
            FN_SLTU: ula_sel_o = ULA_SLTU;
            default: legal_o   = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the multicycle datapath.
// Inputs : clk, rst_n (async, active-low), opcode/funct from the instruction
//          register, alu_zero (all-ones = zero result), mem_ready handshake.
// Outputs: ula_sel, alu_src_a, alu_src_b, pc_src mux selects; pc_write,
//          ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
//          mem_to_reg strobes; illegal_instr pulse; state_o for debug.
// Moore outputs except the FETCH pc/ir writes (gated by mem_ready) and the
// BRANCH pc write (gated by alu_zero).
module multicycle_control
    import types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  opcode_t     opcode,
    input  funct_t      funct,
    input  bus_t        alu_zero,
    input  logic        mem_ready,
    output ula_oper_t   ula_sel,
    output logic        alu_src_a,
    output alu_src_b_t  alu_src_b,
    output pc_src_t     pc_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        illegal_instr,
    output ctrl_state_t state_o
);

    ctrl_state_t state_q, state_d;
    ula_oper_t   fn_ula;
    logic        fn_legal;

    // One decoder serves both the legality check in DECODE and the
    // operation select in EXECUTE; the IR is stable between the two.
    funct_decode u_funct_decode (
        .funct_i   (funct),
        .ula_sel_o (fn_ula),
        .legal_o   (fn_legal)
    );

    // NOTE: state registers use non-blocking assignment so every flop
    // samples its pre-edge value regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        ula_sel       = ULA_ADD;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        pc_src        = PCSRC_ALU;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        iord          = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_instr = 1'b0;
        // Outputs are held at their idle values while reset is asserted so
        // a FETCH under reset does not issue a memory read.
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    // Precompute branch target into ALUOut.
                    alu_src_b = SRCB_IMM_SH2;
                    case (opcode)
                        OP_RTYPE:       state_d = fn_legal ? S_EXECUTE : S_ILLEGAL;
                        OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                        OP_BEQ:         state_d = S_BRANCH;
                        OP_J:           state_d = S_JUMP;
                        OP_ADDI,
                        OP_SLTI:        state_d = S_IMM_EXEC;
                        default:        state_d = S_ILLEGAL;
                    endcase
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    ula_sel   = fn_ula;
                    state_d   = S_ALU_WB;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (mem_ready) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    ula_sel   = ULA_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_write  = (alu_zero == '1);
                    state_d   = S_FETCH;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PCSRC_JUMP;
                    state_d  = S_FETCH;
                end
                S_IMM_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    ula_sel   = (opcode == OP_SLTI) ? ULA_SLT : ULA_ADD;
                    state_d   = S_IMM_WB;
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal_instr = 1'b1;
                    state_d       = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign state_o = state_q;

endmodule
